// File: rtl/matrix_load_sequencer.sv
// Sequential byte fetcher that fills the packed N x N operand buses for matrix A and optionally B.
// Optional wait timeout is enabled with `define MATLOAD_TIMEOUT_EN.
module matrix_load_sequencer #(
    parameter int unsigned N       = 5,
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              load_b_i,
    input  logic [AW-1:0]     base_a_i,
    input  logic [AW-1:0]     base_b_i,
    output logic [AW-1:0]     mem_addr_o,
    output logic              mem_start_o,
    output logic              mem_wr_o,
    input  logic [DW-1:0]     mem_rdata_i,
    input  logic              mem_done_i,
    output logic [N*N*DW-1:0] matrix_a_o,
    output logic [N*N*DW-1:0] matrix_b_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned NumEl = N * N;
    localparam int unsigned IdxW  = (NumEl > 1) ? $clog2(NumEl) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumEl - 1);

    typedef enum logic [1:0] {StIdle, StWait, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d, idx_inc;
    logic                sel_b_q, sel_b_d;
    logic                load_b_q, load_b_d;
    logic [AW-1:0]       base_a_q, base_a_d, base_b_q, base_b_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic                mem_start_q, mem_start_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [NumEl*DW-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;

`ifdef MATLOAD_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sel_b_d     = sel_b_q;
        load_b_d    = load_b_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        mem_addr_d  = mem_addr_q;
        mem_start_d = mem_start_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
`ifdef MATLOAD_TIMEOUT_EN
        // Counter idles at zero outside WAIT so every WAIT entry starts fresh.
        cnt_d       = (state_q == StWait) ? cnt_q : '0;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    load_b_d    = load_b_i;
                    base_a_d    = base_a_i;
                    base_b_d    = base_b_i;
                    idx_d       = '0;
                    sel_b_d     = 1'b0;
                    mem_addr_d  = base_a_i;
                    mem_start_d = 1'b1;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (mem_done_i) begin
                    if (sel_b_q) mat_b_d[DW*idx_q +: DW] = mem_rdata_i;
                    else         mat_a_d[DW*idx_q +: DW] = mem_rdata_i;
                    mem_start_d = 1'b0;
                    state_d     = StGap;
                end
`ifdef MATLOAD_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    mem_start_d = 1'b0;
                    busy_d      = 1'b0;
                    error_d     = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StGap: begin
                if (idx_q == LastIdx && (sel_b_q || !load_b_q)) begin
                    state_d = StDone;
                end else if (idx_q == LastIdx) begin
                    sel_b_d     = 1'b1;
                    idx_d       = '0;
                    mem_addr_d  = base_b_q;
                    mem_start_d = 1'b1;
                    state_d     = StWait;
                end else begin
                    // Address sum is AW bits wide, so it wraps modulo 2^AW.
                    idx_d       = idx_inc;
                    mem_addr_d  = (sel_b_q ? base_b_q : base_a_q) + AW'(idx_inc);
                    mem_start_d = 1'b1;
                    state_d     = StWait;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            sel_b_q     <= 1'b0;
            load_b_q    <= 1'b0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            mem_addr_q  <= '0;
            mem_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_b_q     <= sel_b_d;
            load_b_q    <= load_b_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            mem_addr_q  <= mem_addr_d;
            mem_start_q <= mem_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mat_a_q     <= mat_a_d;
            mat_b_q     <= mat_b_d;
        end
    end

`ifdef MATLOAD_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    assign mem_addr_o  = mem_addr_q;
    assign mem_start_o = mem_start_q;
    assign mem_wr_o    = 1'b0;
    assign matrix_a_o  = mat_a_q;
    assign matrix_b_o  = mat_b_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    // Without the timeout nothing ever sets error_q, so this stays 0.
    assign error_o     = error_q;

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer: table of load scenarios plus reset and timeout sequences.
// Honours MATLOAD_TIMEOUT_EN when the design is built with it.
module tb_matrix_load_sequencer;

    localparam int unsigned N = 5, DW = 8, AW = 8, TO = 255, NE = N * N;

    logic              clk = 1'b0;
    logic              rst, start, load_b;
    logic [AW-1:0]     base_a, base_b, mem_addr;
    logic              mem_start, mem_wr, mem_done;
    logic [DW-1:0]     mem_rdata;
    logic [NE*DW-1:0]  matrix_a, matrix_b;
    logic              busy, done, error;

    always #5 clk = ~clk;

    matrix_load_sequencer #(.N(N), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .load_b_i   (load_b),
        .base_a_i   (base_a),
        .base_b_i   (base_b),
        .mem_addr_o (mem_addr),
        .mem_start_o(mem_start),
        .mem_wr_o   (mem_wr),
        .mem_rdata_i(mem_rdata),
        .mem_done_i (mem_done),
        .matrix_a_o (matrix_a),
        .matrix_b_o (matrix_b),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error)
    );

    // Memory model: mem_done pulses lat cycles after mem_start rises; data = addr ^ 8'h5A.
    int unsigned lat = 1;
    logic        mem_en = 1'b1;
    logic        stray_en = 1'b0;
    logic        md_q;
    int unsigned mcnt;
    logic        stray;

    always_ff @(posedge clk) begin
        if (rst || !mem_start || !mem_en) begin
            mcnt <= 0;
            md_q <= 1'b0;
        end else if (md_q) begin
            md_q <= 1'b0;
        end else if (mcnt == lat - 1) begin
            md_q <= 1'b1;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    // Stray completions land in GAP/DONE with poisoned data.
    assign stray     = stray_en && busy && !mem_start;
    assign mem_done  = md_q | stray;
    assign mem_rdata = stray ? 8'hEE : (mem_addr ^ 8'h5A);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NE*DW-1:0] exp_mat(input logic [7:0] base);
        logic [NE*DW-1:0] m;
        logic [7:0]       a;
        m = '0;
        for (int i = 0; i < NE; i++) begin
            a = base + 8'(i);
            m[i*DW +: DW] = a ^ 8'h5A;
        end
        return m;
    endfunction

    typedef struct {
        logic        load_b;
        logic [7:0]  base_a;
        logic [7:0]  base_b;
        int unsigned lat;
        logic        stray;
        int unsigned exp_done;   // edges after the start-sampling edge until done is seen
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NE*DW-1:0] exp_a, exp_b;
        logic [7:0]       exp_addr;
        int               cyc, reads, ndone, done_cyc, hold_viol, nstart;
        logic             prev_ms, prev_md, stop;

        // Done seen n*(lat+2)+1 edges after the start edge (cycle 77 / 152 counting start as 1).
        vecs[0] = '{1'b0, 8'h10, 8'h00, 1, 1'b0, 76};
        vecs[1] = '{1'b1, 8'h00, 8'h40, 1, 1'b0, 151};
        vecs[2] = '{1'b0, 8'hF0, 8'h00, 1, 1'b0, 76};
        vecs[3] = '{1'b1, 8'h80, 8'h20, 4, 1'b0, 301};
        vecs[4] = '{1'b0, 8'h30, 8'h00, 1, 1'b1, 76};

        rst = 1'b1; start = 1'b0; load_b = 1'b0; base_a = '0; base_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mem_start", mem_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_matrix_a", matrix_a, 0);
        chk("rst_matrix_b", matrix_b, 0);

        exp_b = '0;
        for (int v = 0; v < 5; v++) begin
            exp_a = exp_mat(vecs[v].base_a);
            if (vecs[v].load_b) exp_b = exp_mat(vecs[v].base_b);
            lat = vecs[v].lat;
            stray_en = vecs[v].stray;
            @(negedge clk);
            start = 1'b1; load_b = vecs[v].load_b;
            base_a = vecs[v].base_a; base_b = vecs[v].base_b;
            @(posedge clk); #1;
            start = 1'b0;
            if (vecs[v].stray) begin
                // Inputs change after acceptance; the latched values must be used.
                base_a = 8'hCC; base_b = 8'hDD; load_b = ~vecs[v].load_b;
            end
            chk($sformatf("v%0d_busy_accept", v), busy, 1);
            cyc = 0; reads = 0; ndone = 0; done_cyc = 0; hold_viol = 0;
            prev_ms = 1'b0; prev_md = 1'b0; stop = 1'b0;
            while (!stop) begin
                if (mem_start && !prev_ms) begin
                    exp_addr = (reads < NE) ? vecs[v].base_a + 8'(reads)
                                            : vecs[v].base_b + 8'(reads - NE);
                    chk($sformatf("v%0d_addr%0d", v, reads), mem_addr, exp_addr);
                    reads++;
                end
                if (prev_ms && !mem_start && !prev_md) hold_viol++;
                if (done) begin
                    ndone++;
                    if (ndone == 1) done_cyc = cyc;
                end
                if (vecs[v].stray) start = busy && mem_start && (cyc % 5 == 0);
                prev_ms = mem_start;
                prev_md = mem_done;
                if ((ndone > 0 && cyc >= done_cyc + 3) || cyc > int'(vecs[v].exp_done) + 50)
                    stop = 1'b1;
                else begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
            start = 1'b0;
            stray_en = 1'b0;
            chk($sformatf("v%0d_reads", v), reads, vecs[v].load_b ? 2 * NE : NE);
            chk($sformatf("v%0d_done_count", v), ndone, 1);
            chk($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_done);
            chk($sformatf("v%0d_start_held", v), hold_viol, 0);
            chk($sformatf("v%0d_matrix_a", v), matrix_a, exp_a);
            chk($sformatf("v%0d_matrix_b", v), matrix_b, exp_b);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_error", v), error, 0);
        end
        chk("elem0_of_base10", vecs[0].base_a ^ 8'h5A, 8'h4A);

        // Reset in the middle of an A+B load, while element 12 is outstanding.
        lat = 1;
        @(negedge clk);
        start = 1'b1; load_b = 1'b1; base_a = 8'h00; base_b = 8'h40;
        @(posedge clk); #1;
        start = 1'b0;
        reads = 1; prev_ms = 1'b1; cyc = 0;
        while (reads < 13 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_start && !prev_ms) reads++;
            prev_ms = mem_start;
        end
        chk("midrst_reached_el12", reads, 13);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mem_start", mem_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_matrix_a", matrix_a, 0);
        chk("midrst_matrix_b", matrix_b, 0);
        ndone = 0; nstart = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (mem_start) nstart++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_no_reads", nstart, 0);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; base_a = 8'h10; load_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_busy", busy, 0);
        chk("rst_start_mem_start", mem_start, 0);

        // Memory never answers.
        mem_en = 1'b0;
        @(negedge clk);
        start = 1'b1; load_b = 1'b0; base_a = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
`ifdef MATLOAD_TIMEOUT_EN
        for (int c = 1; c <= 260; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (c == 254) begin
                chk("to_error_before", error, 0);
                chk("to_busy_before", busy, 1);
            end
            if (c == 255) begin
                chk("to_error_at_255", error, 1);
                chk("to_busy_at_255", busy, 0);
                chk("to_mem_start_at_255", mem_start, 0);
            end
        end
        chk("to_no_done", ndone, 0);
        chk("to_error_holds", error, 1);
        mem_en = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("to_error_cleared", error, 0);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("to_reload_done", done, 1);
        chk("to_reload_matrix_a", matrix_a, exp_mat(8'h00));
`else
        repeat (300) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("nto_busy", busy, 1);
        chk("nto_mem_start", mem_start, 1);
        chk("nto_error", error, 0);
        chk("nto_no_done", ndone, 0);
        mem_en = 1'b1;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("nto_recover_busy", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
